// File: rtl/ram_burst_reader_if.sv
// Bundle of the burst-reader command, RAM read-port and output stream signals.
// Latency: none (wiring only).
// Backpressure: carries out_valid/out_ready; master modport is the reader side.
interface ram_burst_reader_if #(
  parameter int ADDR_LEN = 8,
  parameter int DATA_LEN = 8
);
  logic                start;
  logic [ADDR_LEN-1:0] base_addr;
  logic [ADDR_LEN-1:0] len_m1;
  logic                busy;
  logic                done;
  logic                mem_read;
  logic [ADDR_LEN-1:0] mem_addr;
  logic [DATA_LEN-1:0] mem_data;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_LEN-1:0] out_data;
  logic                out_last;

  modport master (
    input  start, base_addr, len_m1, mem_data, out_ready,
    output busy, done, mem_read, mem_addr, out_valid, out_data, out_last
  );

  modport slave (
    output start, base_addr, len_m1, mem_data, out_ready,
    input  busy, done, mem_read, mem_addr, out_valid, out_data, out_last
  );
endinterface

// File: rtl/ram_burst_reader.sv
// Reads a burst of consecutive RAM words and streams them out with a last marker.
// Latency: start in cycle 0, first RAM read in cycle 1, first out_valid in cycle 2.
// Backpressure: one-word output register; RAM read issues only when that register can load.
module ram_burst_reader #(
  parameter int ADDR_LEN = 8,
  parameter int DATA_LEN = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  ram_burst_reader_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_LEN-1:0] addr_q;
  logic [ADDR_LEN-1:0] remaining;
  logic [DATA_LEN-1:0] data_q;
  logic                valid_q;
  logic                last_q;
  logic                done_q;
  logic                can_load;
  logic                issue;
  logic                xfer;

  // Next state plus the combinational RAM read enable (read data is used the same cycle).
  always_comb begin
    state_nxt = state;
    can_load  = !valid_q || bus.out_ready;
    issue     = 1'b0;
    xfer      = valid_q && bus.out_ready;
    case (state)
      IDLE: begin
        if (bus.start) state_nxt = READ;
      end
      READ: begin
        issue = can_load;
        if (issue && (remaining == '0)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (xfer && last_q) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset aborts any burst in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Address/count capture, output word register and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      remaining <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            addr_q    <= bus.base_addr;
            remaining <= bus.len_m1;
          end
        end
        READ: begin
          if (issue) begin
            // A load in the same cycle as a handshake keeps valid high (back-to-back).
            data_q    <= bus.mem_data;
            valid_q   <= 1'b1;
            last_q    <= (remaining == '0);
            addr_q    <= addr_q + 1'b1;
            remaining <= remaining - 1'b1;
          end else if (xfer) begin
            valid_q <= 1'b0;
          end
        end
        DRAIN: begin
          if (xfer) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            if (last_q) done_q <= 1'b1;
          end
        end
        default: begin
          valid_q <= 1'b0;
          last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;
  assign bus.mem_read  = issue;
  assign bus.mem_addr  = addr_q;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_last  = last_q;

endmodule

// File: tb/tb_ram_burst_reader.sv
// Randomized bench for ram_burst_reader against a queue-based burst model.
// Latency: model expects first word two cycles after an accepted start.
// Backpressure: out_ready driven from fixed patterns or random duty cycle.
module tb_ram_burst_reader;
  localparam int AW = 8;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ram_burst_reader_if #(.ADDR_LEN(AW), .DATA_LEN(DW)) bus ();
  ram_burst_reader #(.ADDR_LEN(AW), .DATA_LEN(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // RAM model: real data only while read is enabled, inverted junk otherwise.
  logic [DW-1:0] mem [0:255];
  assign bus.mem_data = bus.mem_read ? mem[bus.mem_addr] : ~mem[bus.mem_addr];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state: words still owed on the stream, plus bookkeeping.
  logic [DW-1:0] exp_data_q [$];
  bit            exp_last_q [$];
  logic [AW-1:0] exp_addr;
  int            words_left;
  bit            exp_busy, busy_next, done_next, first_pending, full_tp;
  bit            held_vld, held_last;
  logic [DW-1:0] held_data;
  int            cyc, start_cyc, cur_len;
  int            ready_pct;
  int            pat_i;
  logic [5:0]    ready_pat;

  task automatic set_ready();
    if (ready_pct < 0) begin
      bus.out_ready = ready_pat[pat_i % 6];
      pat_i++;
    end else begin
      bus.out_ready = ($urandom_range(99) < ready_pct);
    end
  endtask

  // One clock: evaluate settled inputs/outputs before the edge, then check after it.
  task automatic tick();
    bit            exp_rd;
    bit            hs;
    logic [AW-1:0] a;
    logic [DW-1:0] ed;
    bit            el;
    #1;
    exp_rd = exp_busy && (words_left > 0) && (!bus.out_valid || bus.out_ready);
    check("mem_read", bus.mem_read, exp_rd);
    if (bus.mem_read) begin
      check("mem_addr", bus.mem_addr, exp_addr);
      exp_addr = exp_addr + 1'b1;
      words_left--;
    end
    if (held_vld) begin
      check("hold_valid", bus.out_valid, 1);
      check("hold_data", bus.out_data, held_data);
      check("hold_last", bus.out_last, held_last);
    end
    if (bus.out_valid && first_pending) begin
      check("first_latency", cyc - start_cyc, 2);
      first_pending = 0;
    end
    hs = bus.out_valid && bus.out_ready;
    if (hs) begin
      if (exp_data_q.size() == 0) begin
        check("spurious_word", 1, 0);
      end else begin
        ed = exp_data_q.pop_front();
        el = exp_last_q.pop_front();
        check("out_data", bus.out_data, ed);
        check("out_last", bus.out_last, el);
        if (el) begin
          done_next = 1;
          if (full_tp) check("burst_cycles", cyc - start_cyc, cur_len + 2);
        end
      end
    end
    held_vld  = bus.out_valid && !bus.out_ready;
    held_data = bus.out_data;
    held_last = bus.out_last;
    if (bus.start && !exp_busy) begin
      for (int i = 0; i <= int'(bus.len_m1); i++) begin
        a = bus.base_addr + AW'(i);
        exp_data_q.push_back(mem[a]);
        exp_last_q.push_back(i == int'(bus.len_m1));
      end
      exp_addr      = bus.base_addr;
      words_left    = int'(bus.len_m1) + 1;
      start_cyc     = cyc;
      cur_len       = int'(bus.len_m1);
      first_pending = 1;
      busy_next     = 1;
    end
    @(negedge clk);
    cyc++;
    check("done", bus.done, done_next);
    if (done_next) begin
      exp_busy  = 0;
      done_next = 0;
    end
    if (busy_next) begin
      exp_busy  = 1;
      busy_next = 0;
    end
    check("busy", bus.busy, exp_busy);
  endtask

  task automatic run_burst(input logic [AW-1:0] base, input logic [AW-1:0] lm1,
                           input int pct, input bit mid_start);
    int            guard;
    logic [AW-1:0] fin;
    guard     = 0;
    ready_pct = pct;
    pat_i     = 0;
    full_tp   = (pct >= 100);
    fin       = base + lm1 + 1'b1;
    bus.start     = 1'b1;
    bus.base_addr = base;
    bus.len_m1    = lm1;
    set_ready();
    tick();
    while (exp_busy && guard < 3000) begin
      if (mid_start && guard == 3) begin
        bus.start     = 1'b1;
        bus.base_addr = 8'h80;
        bus.len_m1    = 8'h05;
      end else begin
        bus.start     = 1'b0;
        bus.base_addr = AW'($urandom);
        bus.len_m1    = AW'($urandom);
      end
      set_ready();
      tick();
      guard++;
    end
    bus.start = 1'b0;
    if (guard >= 3000) check("timeout", 1, 0);
    check("queue_empty", exp_data_q.size(), 0);
    check("end_addr", bus.mem_addr, fin);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},     bus.busy, 0);
    check({tag, "_done"},     bus.done, 0);
    check({tag, "_mem_read"}, bus.mem_read, 0);
    check({tag, "_mem_addr"}, bus.mem_addr, 0);
    check({tag, "_valid"},    bus.out_valid, 0);
    check({tag, "_data"},     bus.out_data, 0);
    check({tag, "_last"},     bus.out_last, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = DW'(i) ^ 8'hA5;
    ready_pat     = 6'b101001;
    exp_busy      = 0; busy_next = 0; done_next = 0; first_pending = 0;
    held_vld      = 0; words_left = 0; exp_addr = '0; cyc = 0; start_cyc = 0;
    cur_len       = 0; full_tp = 0; ready_pct = 100; pat_i = 0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.len_m1    = '0;
    bus.out_ready = 1'b0;
    #3;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_burst(8'h10, 8'd3, 100, 0);   // basic four-word burst
    run_burst(8'hFE, 8'd2, 100, 0);   // address wrap
    run_burst(8'h50, 8'd4, -1, 0);    // backpressure 1,0,0,1,0,1...
    run_burst(8'h33, 8'd0, 100, 0);   // single word
    run_burst(8'h34, 8'd0, 50, 0);    // issued in the done cycle
    run_burst(8'h20, 8'd9, 100, 1);   // start with base 0x80 mid-burst is ignored

    // Async reset after two of eight words.
    ready_pct = 100; full_tp = 1;
    bus.start = 1'b1; bus.base_addr = 8'h40; bus.len_m1 = 8'd7; bus.out_ready = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick();
    check("pre_reset_words_left", exp_data_q.size(), 6);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    exp_data_q.delete(); exp_last_q.delete();
    exp_busy = 0; busy_next = 0; done_next = 0; first_pending = 0;
    held_vld = 0; words_left = 0; exp_addr = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("post_reset_addr", bus.mem_addr, 0);

    // Whole memory once, then randomized bursts.
    run_burst(8'h77, 8'hFF, 100, 0);
    for (int n = 0; n < 25; n++) begin
      run_burst(AW'($urandom), AW'($urandom_range(0, 40)),
                $urandom_range(30, 100), ($urandom_range(1) == 1));
    end
    for (int i = 0; i < 3; i++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
